// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and shared-ALU signals for alu_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and ALU's view.
interface alu_arbiter_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_funct;
    logic [XLEN-1:0]  req0_a;
    logic [XLEN-1:0]  req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_funct;
    logic [XLEN-1:0]  req1_a;
    logic [XLEN-1:0]  req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic [3:0]       alu_funct;
    logic [XLEN-1:0]  alu_operand_a;
    logic [XLEN-1:0]  alu_operand_b;
    logic [XLEN-1:0]  alu_result;
    logic             alu_result_eq_zero;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [XLEN-1:0]  rsp0_result;
    logic             rsp0_zero;
    logic [TAG_W-1:0] rsp0_tag;

    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [XLEN-1:0]  rsp1_result;
    logic             rsp1_zero;
    logic [TAG_W-1:0] rsp1_tag;

    modport slave (
        input  req0_valid, req0_funct, req0_a, req0_b, req0_tag,
        input  req1_valid, req1_funct, req1_a, req1_b, req1_tag,
        output req0_ready, req1_ready,
        output alu_funct, alu_operand_a, alu_operand_b,
        input  alu_result, alu_result_eq_zero,
        output rsp0_valid, rsp0_result, rsp0_zero, rsp0_tag,
        output rsp1_valid, rsp1_result, rsp1_zero, rsp1_tag,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_funct, req0_a, req0_b, req0_tag,
        output req1_valid, req1_funct, req1_a, req1_b, req1_tag,
        input  req0_ready, req1_ready,
        input  alu_funct, alu_operand_a, alu_operand_b,
        output alu_result, alu_result_eq_zero,
        input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_tag,
        input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_tag,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, with per-requester response slots.
// Define ALU_ARB_FIXED_PRIO_EN for strict req0 priority; default build is round-robin.
module alu_arbiter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 4
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    logic             elig0, elig1;
    logic             grant0, grant1;

    logic             rsp0_valid_q, rsp1_valid_q;
    logic [XLEN-1:0]  rsp0_result_q, rsp1_result_q;
    logic             rsp0_zero_q, rsp1_zero_q;
    logic [TAG_W-1:0] rsp0_tag_q, rsp1_tag_q;

    // A slot that is draining this cycle can accept a new result on the same edge.
    assign elig0 = bus.req0_valid && (!rsp0_valid_q || bus.rsp0_ready);
    assign elig1 = bus.req1_valid && (!rsp1_valid_q || bus.rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = elig0;
        grant1 = elig1 && !elig0;
    end
`else
    typedef enum logic {
        LG_REQ0 = 1'b0,
        LG_REQ1 = 1'b1
    } last_grant_e;

    last_grant_e last_grant, last_grant_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= LG_REQ1;
        end else begin
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        grant0         = 1'b0;
        grant1         = 1'b0;
        last_grant_nxt = last_grant;
        if (elig0 && elig1) begin
            grant0 = (last_grant == LG_REQ1);
            grant1 = (last_grant == LG_REQ0);
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
        if (grant0) begin
            last_grant_nxt = LG_REQ0;
        end else if (grant1) begin
            last_grant_nxt = LG_REQ1;
        end
    end
`endif

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        bus.alu_funct     = '0;
        bus.alu_operand_a = '0;
        bus.alu_operand_b = '0;
        if (grant0) begin
            bus.alu_funct     = bus.req0_funct;
            bus.alu_operand_a = bus.req0_a;
            bus.alu_operand_b = bus.req0_b;
        end else if (grant1) begin
            bus.alu_funct     = bus.req1_funct;
            bus.alu_operand_a = bus.req1_a;
            bus.alu_operand_b = bus.req1_b;
        end
    end

    // A new grant takes precedence over a drain so back-to-back results keep valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp0_tag_q    <= '0;
        end else if (grant0) begin
            rsp0_valid_q  <= 1'b1;
            rsp0_result_q <= bus.alu_result;
            rsp0_zero_q   <= bus.alu_result_eq_zero;
            rsp0_tag_q    <= bus.req0_tag;
        end else if (rsp0_valid_q && bus.rsp0_ready) begin
            rsp0_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_zero_q   <= 1'b0;
            rsp1_tag_q    <= '0;
        end else if (grant1) begin
            rsp1_valid_q  <= 1'b1;
            rsp1_result_q <= bus.alu_result;
            rsp1_zero_q   <= bus.alu_result_eq_zero;
            rsp1_tag_q    <= bus.req1_tag;
        end else if (rsp1_valid_q && bus.rsp1_ready) begin
            rsp1_valid_q  <= 1'b0;
        end
    end

    assign bus.rsp0_valid  = rsp0_valid_q;
    assign bus.rsp0_result = rsp0_result_q;
    assign bus.rsp0_zero   = rsp0_zero_q;
    assign bus.rsp0_tag    = rsp0_tag_q;
    assign bus.rsp1_valid  = rsp1_valid_q;
    assign bus.rsp1_result = rsp1_result_q;
    assign bus.rsp1_zero   = rsp1_zero_q;
    assign bus.rsp1_tag    = rsp1_tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios followed by random traffic.
// Honours ALU_ARB_FIXED_PRIO_EN to select the expected arbitration policy.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RISC-V style ALU semantics, used both as the external ALU and as the reference.
    function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] f, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        case (f)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[5:0];
            4'b0010: return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            4'b0011: return {{(XLEN-1){1'b0}}, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[5:0];
            4'b1101: return $unsigned($signed(a) >>> b[5:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a + b;
        endcase
    endfunction

    always_comb begin
        bus.alu_result         = ref_alu(bus.alu_funct, bus.alu_operand_a, bus.alu_operand_b);
        bus.alu_result_eq_zero = (bus.alu_result == '0);
    end

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic             z;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    rsp_t q0[$];
    rsp_t q1[$];

    int  total = 0;
    int  bad   = 0;
    bit  exp_occ0, exp_occ1;
    bit  last1 = 1'b1;
    bit  rst_prev = 1'b1;
    bit  final_chk = 1'b0;
    bit  e0, e1, g0, g1;
    rsp_t cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: runs 2ns after each falling edge, once the driver has settled inputs.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            exp_occ0 = 1'b0;
            exp_occ1 = 1'b0;
            last1    = 1'b1;
            rst_prev = 1'b1;
        end else begin
            if (rst_prev) begin
                chk("rst_rsp0_result", bus.rsp0_result, 64'd0);
                chk("rst_rsp0_zero",   64'(bus.rsp0_zero), 64'd0);
                chk("rst_rsp0_tag",    64'(bus.rsp0_tag), 64'd0);
                chk("rst_rsp1_result", bus.rsp1_result, 64'd0);
                chk("rst_rsp1_zero",   64'(bus.rsp1_zero), 64'd0);
                chk("rst_rsp1_tag",    64'(bus.rsp1_tag), 64'd0);
                rst_prev = 1'b0;
            end

            e0 = bus.req0_valid && (!exp_occ0 || bus.rsp0_ready);
            e1 = bus.req1_valid && (!exp_occ1 || bus.rsp1_ready);
`ifdef ALU_ARB_FIXED_PRIO_EN
            g0 = e0;
            g1 = e1 && !e0;
`else
            if (e0 && e1) begin
                g0 = last1;
                g1 = !last1;
            end else begin
                g0 = e0;
                g1 = e1;
            end
`endif
            chk("req0_ready", 64'(bus.req0_ready), 64'(g0));
            chk("req1_ready", 64'(bus.req1_ready), 64'(g1));
            chk("rsp0_valid", 64'(bus.rsp0_valid), 64'(exp_occ0));
            chk("rsp1_valid", 64'(bus.rsp1_valid), 64'(exp_occ1));

            if (exp_occ0 && q0.size() > 0) begin
                cur = q0[0];
                chk("rsp0_result", bus.rsp0_result, cur.res);
                chk("rsp0_zero", 64'(bus.rsp0_zero), 64'(cur.z));
                chk("rsp0_tag", 64'(bus.rsp0_tag), 64'(cur.tag));
                if (bus.rsp0_ready) void'(q0.pop_front());
            end
            if (exp_occ1 && q1.size() > 0) begin
                cur = q1[0];
                chk("rsp1_result", bus.rsp1_result, cur.res);
                chk("rsp1_zero", 64'(bus.rsp1_zero), 64'(cur.z));
                chk("rsp1_tag", 64'(bus.rsp1_tag), 64'(cur.tag));
                if (bus.rsp1_ready) void'(q1.pop_front());
            end

            if (g0) begin
                chk("alu_funct", 64'(bus.alu_funct), 64'(bus.req0_funct));
                chk("alu_a", bus.alu_operand_a, bus.req0_a);
                chk("alu_b", bus.alu_operand_b, bus.req0_b);
                cur.res = ref_alu(bus.req0_funct, bus.req0_a, bus.req0_b);
                cur.z   = (cur.res == '0);
                cur.tag = bus.req0_tag;
                q0.push_back(cur);
                last1 = 1'b0;
            end else if (g1) begin
                chk("alu_funct", 64'(bus.alu_funct), 64'(bus.req1_funct));
                chk("alu_a", bus.alu_operand_a, bus.req1_a);
                chk("alu_b", bus.alu_operand_b, bus.req1_b);
            end else begin
                chk("alu_idle_funct", 64'(bus.alu_funct), 64'd0);
                chk("alu_idle_a", bus.alu_operand_a, 64'd0);
                chk("alu_idle_b", bus.alu_operand_b, 64'd0);
            end
            if (g1) begin
                cur.res = ref_alu(bus.req1_funct, bus.req1_a, bus.req1_b);
                cur.z   = (cur.res == '0);
                cur.tag = bus.req1_tag;
                q1.push_back(cur);
                last1 = 1'b1;
            end

            exp_occ0 = g0 || (exp_occ0 && !bus.rsp0_ready);
            exp_occ1 = g1 || (exp_occ1 && !bus.rsp1_ready);

            if (final_chk) begin
                chk("q0_drained", 64'(q0.size()), 64'd0);
                chk("q1_drained", 64'(q1.size()), 64'd0);
            end
        end
    end

    task automatic drv(input bit v0, input logic [3:0] f0, input logic [63:0] a0,
                       input logic [63:0] b0, input logic [3:0] t0,
                       input bit v1, input logic [3:0] f1, input logic [63:0] a1,
                       input logic [63:0] b1, input logic [3:0] t1,
                       input bit r0, input bit r1);
        bus.req0_valid = v0; bus.req0_funct = f0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_tag = t0;
        bus.req1_valid = v1; bus.req1_funct = f1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_tag = t1;
        bus.rsp0_ready = r0;
        bus.rsp1_ready = r1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: v = 64'(v[3:0]);
            1: v = 64'(v[7:0]);
            default: ;
        endcase
        return v;
    endfunction

    bit acc0, acc1;

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single op: ADD 5+7 tag 3.
        drv(1, 4'b0000, 64'd5, 64'd7, 4'd3, 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // Contention: both valid for 4 cycles, req1 SUB 9-9.
        for (int i = 0; i < 4; i++)
            drv(1, 4'b0000, 64'd20 + 64'(i), 64'd1, 4'(i), 1, 4'b1000, 64'd9, 64'd9, 4'(8 + i), 1, 1);
        idle(2);

        // Backpressure on rsp0 while req1 keeps streaming.
        drv(1, 4'b0100, 64'h1234, 64'h00ff, 4'd5, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++)
            drv(1, 4'b0110, 64'h0a00, 64'h000b, 4'd6, 1, 4'b0000, 64'(100 + i), 64'd1, 4'(i), 0, 1);
        drv(1, 4'b0110, 64'h0a00, 64'h000b, 4'd6, 1, 4'b0000, 64'd200, 64'd1, 4'd9, 1, 1);
        idle(3);

        // Streaming: five distinct req0 ops back-to-back.
        for (int i = 0; i < 5; i++)
            drv(1, 4'b0000, 64'(1000 * (i + 1)), 64'd3, 4'(i + 1), 0, 0, 0, 0, 0, 1, 1);
        idle(2);

        // Reset mid-op: req1 XOR accepted, then reset on the next edge.
        drv(0, 0, 0, 0, 0, 1, 4'b0100, 64'hf0, 64'hff, 4'd7, 1, 1);
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            drv(1, 4'b0111, 64'hff00, 64'(i), 4'd2, 1, 4'b0011, 64'(i), 64'd2, 4'd4, 1, 1);
        // Strict-priority corner: req0 stops, req1 must then be served.
        drv(0, 0, 0, 0, 0, 1, 4'b0011, 64'd1, 64'd2, 4'd4, 1, 1);
        idle(2);

        // Random traffic: payloads held until accepted.
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.req0_valid || acc0) begin
                bus.req0_valid = ($urandom_range(0, 3) != 0);
                bus.req0_funct = 4'($urandom_range(0, 15));
                bus.req0_a     = rnd_operand();
                bus.req0_b     = ($urandom_range(0, 4) == 0) ? bus.req0_a : rnd_operand();
                bus.req0_tag   = 4'($urandom);
            end
            if (!bus.req1_valid || acc1) begin
                bus.req1_valid = ($urandom_range(0, 3) != 0);
                bus.req1_funct = 4'($urandom_range(0, 15));
                bus.req1_a     = rnd_operand();
                bus.req1_b     = ($urandom_range(0, 4) == 0) ? bus.req1_a : rnd_operand();
                bus.req1_tag   = 4'($urandom);
            end
            bus.rsp0_ready = ($urandom_range(0, 9) < 7);
            bus.rsp1_ready = ($urandom_range(0, 9) < 7);
            #1;
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            @(negedge clk);
        end

        idle(4);
        final_chk = 1'b1;
        idle(1);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
